// File: rtl/threshold_dac_arb.sv
// Round-robin arbiter sharing one multi-channel threshold DAC between N_CH measure
// controllers: per-channel shadow/pending capture, DAC write handshake, settle timing.
module threshold_dac_arb #(
    parameter int N_CH = 4,
    parameter int DW   = 16,
    localparam int CW  = $clog2(N_CH)
) (
    input  logic               clk_i,
    input  logic               arst_i,
    input  logic [N_CH*DW-1:0] ch_threshold_i,
    input  logic [N_CH-1:0]    ch_wre_i,
    output logic [N_CH-1:0]    ch_rdy_o,
    input  logic [15:0]        settle_cycles_i,
    output logic [DW-1:0]      dac_data_o,
    output logic [CW-1:0]      dac_ch_o,
    output logic               dac_wr_o,
    input  logic               dac_busy_i,
    output logic               busy_o,
    output logic [1:0]         state_o
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ISSUE  = 2'd1;
    localparam logic [1:0] ST_BUSY   = 2'd2;
    localparam logic [1:0] ST_SETTLE = 2'd3;

    logic [1:0]                 state_q, state_d;
    logic [N_CH-1:0]            pend_q, pend_d;
    logic [N_CH-1:0][DW-1:0]    shadow_q, shadow_d;
    logic [N_CH-1:0]            rdy_q, rdy_d;
    logic                       wr_q, wr_d;
    logic [DW-1:0]              data_q, data_d;
    logic [CW-1:0]              ch_q, ch_d;
    logic [15:0]                cnt_q, cnt_d;
    logic [CW-1:0]              last_q, last_d;
    logic [CW:0]                pick;
    logic                       complete;

    // Returns {found, index}; searches from last+1 upward so the nearest channel wins.
    function automatic logic [CW:0] rr_pick(input logic [N_CH-1:0] pend,
                                            input logic [CW-1:0] last);
        logic [CW:0]   res;
        int            idx;
        logic [CW-1:0] idx_c;
        res = '0;
        for (int i = N_CH; i >= 1; i--) begin
            idx   = (int'(last) + i) % N_CH;
            idx_c = idx[CW-1:0];
            if (pend[idx_c]) res = {1'b1, idx_c};
        end
        return res;
    endfunction

    always_comb begin
        state_d  = state_q;
        pend_d   = pend_q;
        shadow_d = shadow_q;
        rdy_d    = rdy_q;
        wr_d     = wr_q;
        data_d   = data_q;
        ch_d     = ch_q;
        cnt_d    = cnt_q;
        last_d   = last_q;
        complete = 1'b0;
        pick     = rr_pick(pend_q, last_q);

        for (int k = 0; k < N_CH; k++) begin
            if (ch_wre_i[k]) begin
                shadow_d[k] = ch_threshold_i[k*DW +: DW];
                pend_d[k]   = 1'b1;
                rdy_d[k]    = 1'b0;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (pick[CW]) begin
                    // Grant uses the pre-capture shadow; a same-cycle write stays pending.
                    data_d = shadow_q[pick[CW-1:0]];
                    ch_d   = pick[CW-1:0];
                    if (!ch_wre_i[pick[CW-1:0]]) pend_d[pick[CW-1:0]] = 1'b0;
                    cnt_d   = settle_cycles_i;
                    wr_d    = 1'b1;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (dac_busy_i) begin
                    wr_d    = 1'b0;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (!dac_busy_i) begin
                    if (cnt_q != 16'd0) state_d = ST_SETTLE;
                    else                complete = 1'b1;
                end
            end
            default: begin
                cnt_d = cnt_q - 16'd1;
                if (cnt_q <= 16'd1) complete = 1'b1;
            end
        endcase

        if (complete) begin
            state_d     = ST_IDLE;
            last_d      = ch_q;
            rdy_d[ch_q] = !pend_d[ch_q];
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q  <= ST_IDLE;
            pend_q   <= '0;
            shadow_q <= '0;
            rdy_q    <= '0;
            wr_q     <= 1'b0;
            data_q   <= '0;
            ch_q     <= '0;
            cnt_q    <= '0;
            last_q   <= CW'(N_CH - 1);
        end else begin
            state_q  <= state_d;
            pend_q   <= pend_d;
            shadow_q <= shadow_d;
            rdy_q    <= rdy_d;
            wr_q     <= wr_d;
            data_q   <= data_d;
            ch_q     <= ch_d;
            cnt_q    <= cnt_d;
            last_q   <= last_d;
        end
    end

    assign ch_rdy_o   = rdy_q;
    assign dac_data_o = data_q;
    assign dac_ch_o   = ch_q;
    assign dac_wr_o   = wr_q;
    assign busy_o     = (state_q != ST_IDLE);
    assign state_o    = state_q;

endmodule

// File: tb/tb_threshold_dac_arb.sv
// Directed bench for threshold_dac_arb: the bench plays the DAC driver and checks
// grant order, handshake, settle timing, overwrite/re-request and reset behaviour.
module tb_threshold_dac_arb;

    localparam int N_CH = 4;
    localparam int DW   = 16;
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ISSUE  = 2'd1;
    localparam logic [1:0] S_BUSY   = 2'd2;
    localparam logic [1:0] S_SETTLE = 2'd3;

    logic               clk = 1'b0;
    logic               arst;
    logic [N_CH*DW-1:0] thr;
    logic [N_CH-1:0]    wre;
    logic [N_CH-1:0]    rdy;
    logic [15:0]        settle;
    logic [DW-1:0]      dac_data;
    logic [1:0]         dac_ch;
    logic               dac_wr;
    logic               dac_busy;
    logic               busy;
    logic [1:0]         state;

    int checks   = 0;
    int failures = 0;

    threshold_dac_arb #(.N_CH(N_CH), .DW(DW)) dut (
        .clk_i(clk), .arst_i(arst), .ch_threshold_i(thr), .ch_wre_i(wre),
        .ch_rdy_o(rdy), .settle_cycles_i(settle), .dac_data_o(dac_data),
        .dac_ch_o(dac_ch), .dac_wr_o(dac_wr), .dac_busy_i(dac_busy),
        .busy_o(busy), .state_o(state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_thr(input int k, input logic [DW-1:0] v);
        thr[k*DW +: DW] = v;
    endtask

    task automatic exp_issue(input logic [1:0] ch, input logic [DW-1:0] data);
        chk("issue_wr", dac_wr, 1);
        chk("issue_ch", dac_ch, ch);
        chk("issue_data", dac_data, data);
        chk("issue_state", state, S_ISSUE);
        chk("issue_busy_o", busy, 1);
    endtask

    task automatic ack_hold(input int n);
        dac_busy = 1'b1;
        tick();
        chk("ack_wr_low", dac_wr, 0);
        chk("ack_state", state, S_BUSY);
        for (int i = 1; i < n; i++) tick();
        chk("busy_hold_state", state, S_BUSY);
    endtask

    task automatic release_settle(input int ch, input int s, input logic exp_rdy);
        dac_busy = 1'b0;
        tick();
        if (s == 0) begin
            chk("rdy_settle0", rdy[ch], exp_rdy);
            chk("done_state0", state, S_IDLE);
        end else begin
            chk("settle_state", state, S_SETTLE);
            chk("settle_rdy_low", rdy[ch], 0);
            for (int i = 1; i < s; i++) begin
                tick();
                chk("settle_rdy_low", rdy[ch], 0);
            end
            tick();
            chk("rdy_after_settle", rdy[ch], exp_rdy);
            chk("done_state", state, S_IDLE);
        end
    endtask

    initial begin
        arst = 1'b1; thr = '0; wre = '0; settle = '0; dac_busy = 1'b0;
        tick();
        chk("rst_state", state, S_IDLE);
        chk("rst_busy", busy, 0);
        chk("rst_wr", dac_wr, 0);
        chk("rst_data", dac_data, 0);
        chk("rst_ch", dac_ch, 0);
        chk("rst_rdy", rdy, 0);
        arst = 1'b0;
        tick();

        // single request, delayed ack, 4-cycle busy, settle 3
        set_thr(2, 16'h1234); settle = 16'd3; wre = 4'b0100;
        tick();
        wre = '0;
        chk("capture_idle", state, S_IDLE);
        tick();
        exp_issue(2'd2, 16'h1234);
        tick();
        chk("wr_hold", dac_wr, 1);
        chk("data_hold", dac_data, 16'h1234);
        ack_hold(4);
        chk("busy_rdy_low", rdy[2], 0);
        release_settle(2, 3, 1'b1);

        // settle = 0
        set_thr(1, 16'h00ab); settle = 16'd0; wre = 4'b0010;
        tick();
        wre = '0;
        tick();
        exp_issue(2'd1, 16'h00ab);
        ack_hold(1);
        release_settle(1, 0, 1'b1);
        chk("rdy2_kept", rdy[2], 1);

        // overwrite of ch1 while ch0 is in BUSY
        set_thr(0, 16'h0100); settle = 16'd1; wre = 4'b0001;
        tick();
        wre = '0;
        tick();
        exp_issue(2'd0, 16'h0100);
        dac_busy = 1'b1;
        tick();
        chk("ovw_busy", state, S_BUSY);
        set_thr(1, 16'h0010); wre = 4'b0010;
        tick();
        set_thr(1, 16'h0020);
        tick();
        wre = '0;
        chk("ovw_rdy1_low", rdy[1], 0);
        release_settle(0, 1, 1'b1);
        tick();
        exp_issue(2'd1, 16'h0020);
        ack_hold(1);
        release_settle(1, 1, 1'b1);
        tick();
        chk("ovw_single_write", busy, 0);
        chk("ovw_wr_idle", dac_wr, 0);

        // re-request of ch0 during its own SETTLE
        set_thr(0, 16'h0004); settle = 16'd2; wre = 4'b0001;
        tick();
        wre = '0;
        tick();
        exp_issue(2'd0, 16'h0004);
        ack_hold(1);
        dac_busy = 1'b0;
        tick();
        chk("rereq_settle", state, S_SETTLE);
        set_thr(0, 16'h0005); wre = 4'b0001;
        tick();
        wre = '0;
        chk("rereq_rdy_low_a", rdy[0], 0);
        tick();
        chk("rereq_done", state, S_IDLE);
        chk("rereq_rdy_low_b", rdy[0], 0);
        tick();
        exp_issue(2'd0, 16'h0005);
        ack_hold(1);
        release_settle(0, 2, 1'b1);

        // write arriving on the grant cycle of the same channel
        set_thr(3, 16'h0033); settle = 16'd0; wre = 4'b1000;
        tick();
        set_thr(3, 16'h0044);
        tick();
        wre = '0;
        exp_issue(2'd3, 16'h0033);
        ack_hold(1);
        release_settle(3, 0, 1'b0);
        tick();
        exp_issue(2'd3, 16'h0044);
        ack_hold(1);
        release_settle(3, 0, 1'b1);

        // asynchronous reset during BUSY
        set_thr(1, 16'h0111); set_thr(2, 16'h0777); settle = 16'd5; wre = 4'b0110;
        tick();
        wre = '0;
        tick();
        exp_issue(2'd1, 16'h0111);
        ack_hold(2);
        #2 arst = 1'b1;
        #1;
        chk("arst_state", state, S_IDLE);
        chk("arst_busy", busy, 0);
        chk("arst_wr", dac_wr, 0);
        chk("arst_data", dac_data, 0);
        chk("arst_ch", dac_ch, 0);
        chk("arst_rdy", rdy, 0);
        dac_busy = 1'b0;
        #1 arst = 1'b0;
        tick();
        tick();
        chk("arst_pending_lost", busy, 0);
        chk("arst_no_write", dac_wr, 0);

        // all four channels at once, served 0,1,2,3
        for (int k = 0; k < N_CH; k++) set_thr(k, 16'ha000 + 16'(k));
        settle = 16'd1; wre = 4'b1111;
        tick();
        wre = '0;
        chk("cont_rdy_all_low", rdy, 0);
        for (int k = 0; k < N_CH; k++) begin
            tick();
            exp_issue(2'(k), 16'ha000 + 16'(k));
            ack_hold(1);
            chk("cont_rdy_before", rdy, (32'd1 << k) - 1);
            release_settle(k, 1, 1'b1);
            chk("cont_rdy_after", rdy, (32'd1 << (k + 1)) - 1);
        end
        tick();
        chk("cont_idle_end", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/threshold_dac_arb.md
THRESHOLD_DAC_ARB -- requirements
Module: threshold_dac_arb

Interface
REQ-001 Parameter N_CH, default 4, number of channel measure controllers sharing one multi-channel threshold DAC (2..8).
REQ-002 Parameter DW, default 16, threshold word width.
REQ-003 clk_i  input  1  clock; all state changes on posedge.
REQ-004 arst_i  input  1  reset, asynchronous, active-high.
REQ-005 ch_threshold_i  input  N_CH*DW  per-channel requested threshold; channel k occupies bits [k*DW +: DW].
REQ-006 ch_wre_i  input  N_CH  per-channel single-cycle write request.
REQ-007 ch_rdy_o  output  N_CH  per-channel "DAC output at last requested value and settled".
REQ-008 settle_cycles_i  input  16  settle time in clk cycles, sampled at grant.
REQ-009 dac_data_o  output  DW  value for the DAC driver.
REQ-010 dac_ch_o  output  $clog2(N_CH)  DAC output channel index.
REQ-011 dac_wr_o  output  1  level request to the DAC driver.
REQ-012 dac_busy_i  input  1  DAC driver busy/acknowledge.
REQ-013 busy_o  output  1  high in any state other than IDLE.

Function
REQ-014 Per channel k: pending flag and DW-bit shadow register; ch_wre_i[k]=1 captures ch_threshold_i[k] into shadow, sets pending, drives ch_rdy_o[k]=0 on the next cycle.
REQ-015 Repeated ch_wre_i[k] while pending and not granted overwrites shadow (latest value wins); only one DAC write issued.
REQ-016 States: IDLE, ISSUE, BUSY, SETTLE.
REQ-017 IDLE: if any pending, grant by round-robin starting at index (last_grant+1) mod N_CH; load dac_data_o=shadow, dac_ch_o=grant, clear that pending flag, latch settle count, go ISSUE; last_grant resets to N_CH-1, so channel 0 has first priority.
REQ-018 ISSUE: dac_wr_o=1; dac_data_o/dac_ch_o held constant; on dac_busy_i=1 deassert dac_wr_o next cycle, go BUSY.
REQ-019 BUSY: wait for dac_busy_i=0; then go SETTLE if latched count>0, else complete.
REQ-020 SETTLE: 16-bit down-counter from latched value, decrements per cycle; complete on the cycle count reaches 1 (exactly settle_cycles_i cycles spent in SETTLE).
REQ-021 Complete: return to IDLE; ch_rdy_o[grant]=1 only if channel not pending again, else stays 0; last_grant=grant.
REQ-022 ch_wre_i[grant] arriving during ISSUE/BUSY/SETTLE sets pending with new shadow; in-flight transaction completes with old value; ch_rdy_o[grant] remains 0 and channel is rearbitrated.
REQ-023 ch_wre_i on the same cycle as the grant of that channel: the granted value is the pre-capture shadow; the new value becomes pending.
REQ-024 Simultaneous requests from several channels all captured in the same cycle; served one per transaction in round-robin order.
REQ-025 Minimum transaction: 1 cycle IDLE + ISSUE until ack + BUSY until release + settle; no new grant in the completion cycle (grant earliest next IDLE cycle).
REQ-026 Channels without requests keep ch_rdy_o unchanged; arbitration never starves: any pending channel granted within N_CH transactions.
REQ-027 dac_busy_i already high in the first ISSUE cycle is taken as acknowledge.

Reset
REQ-028 arst_i=1 forces immediately: state IDLE, all pending=0, shadows=0, ch_rdy_o=0, dac_wr_o=0, dac_data_o=0, dac_ch_o=0, busy_o=0, counter=0, last_grant=N_CH-1.
REQ-029 Reset mid-transaction abandons it; no completion, no ch_rdy_o assertion; DAC driver resynchronises on dac_wr_o=0.

Verification
REQ-030 Single: ch_wre_i[2] with 0x1234, settle=3, driver acks 1 cycle, busy 4 cycles -> one dac_wr_o, dac_ch_o=2, dac_data_o=0x1234, ch_rdy_o[2] rises exactly 3 cycles after busy falls.
REQ-031 Contention: ch_wre_i=4'b1111 same cycle -> grants in order 0,1,2,3; each ch_rdy_o rises only after its own transaction.
REQ-032 Overwrite: ch_wre_i[1] 0x0010 then 0x0020 while channel 0 in BUSY -> single write of 0x0020 to channel 1.
REQ-033 Re-request in flight: ch_wre_i[0] 0x0005 during SETTLE of ch0 0x0004 -> ch_rdy_o[0] stays 0, second write 0x0005, then ch_rdy_o[0]=1.
REQ-034 Settle=0 -> ch_rdy_o asserts the cycle after BUSY sees dac_busy_i=0.
REQ-035 arst_i pulse during BUSY -> all outputs at reset values, pending lost, later request served normally from channel 0 priority.
